// File: rtl/aes_decipher_block.sv
// AES-128 inverse cipher datapath. The round keys come from an external key memory and the
// inverse S-box sits outside this block. Each round substitutes one 32-bit word per cycle.
module aes_decipher_block #(
    parameter int unsigned NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic [127:0] block,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    output logic [31:0]  inv_sboxw,
    input  logic [31:0]  new_inv_sboxw,
    output logic         ready,
    output logic [127:0] new_block
);

    typedef enum logic [2:0] {StIdle, StInit, StSbox, StRound, StDone} state_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);

    state_e       state_q, state_d;
    logic [127:0] block_q, block_d;
    logic [3:0]   round_ctr_q, round_ctr_d;
    logic [1:0]   word_ctr_q, word_ctr_d;
    logic         ready_q, ready_d;
    logic [127:0] addkey;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mul_b(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] mul_d(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mul_e(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = c;
        return {mul_e(b0) ^ mul_b(b1) ^ mul_d(b2) ^ mul_9(b3),
                mul_9(b0) ^ mul_e(b1) ^ mul_b(b2) ^ mul_d(b3),
                mul_d(b0) ^ mul_9(b1) ^ mul_e(b2) ^ mul_b(b3),
                mul_b(b0) ^ mul_d(b1) ^ mul_9(b2) ^ mul_e(b3)};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]), inv_mix_col(s[31:0])};
    endfunction

    // Byte index is 4*col + row, byte 0 in the top bits; row r rotates right by r columns.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    assign addkey    = block_q ^ round_key;
    assign ready     = ready_q;
    assign new_block = block_q;

    // Next-state logic plus the key-index and S-box word presented to the outside.
    always_comb begin
        state_d     = state_q;
        block_d     = block_q;
        round_ctr_d = round_ctr_q;
        word_ctr_d  = word_ctr_q;
        ready_d     = ready_q;
        round       = 4'd0;
        inv_sboxw   = block_q[127:96];
        unique case (state_q)
            StIdle: begin
                if (next) begin
                    block_d     = block;
                    ready_d     = 1'b0;
                    round_ctr_d = LastRound;
                    state_d     = StInit;
                end
            end
            StInit: begin
                round       = LastRound;
                block_d     = inv_shift_rows(addkey);
                round_ctr_d = round_ctr_q - 4'd1;
                word_ctr_d  = 2'd0;
                state_d     = StSbox;
            end
            StSbox: begin
                round = round_ctr_q;
                unique case (word_ctr_q)
                    2'd0: begin
                        inv_sboxw        = block_q[127:96];
                        block_d[127:96]  = new_inv_sboxw;
                    end
                    2'd1: begin
                        inv_sboxw        = block_q[95:64];
                        block_d[95:64]   = new_inv_sboxw;
                    end
                    2'd2: begin
                        inv_sboxw        = block_q[63:32];
                        block_d[63:32]   = new_inv_sboxw;
                    end
                    2'd3: begin
                        inv_sboxw        = block_q[31:0];
                        block_d[31:0]    = new_inv_sboxw;
                    end
                    default: ;
                endcase
                word_ctr_d = word_ctr_q + 2'd1;
                if (word_ctr_q == 2'd3) begin
                    state_d = StRound;
                end
            end
            StRound: begin
                round = round_ctr_q;
                if (round_ctr_q != 4'd0) begin
                    block_d     = inv_shift_rows(inv_mix_columns(addkey));
                    round_ctr_d = round_ctr_q - 4'd1;
                    word_ctr_d  = 2'd0;
                    state_d     = StSbox;
                end else begin
                    // Final round skips InvMixColumns.
                    block_d = addkey;
                    state_d = StDone;
                end
            end
            StDone: begin
                ready_d = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset aborts any operation and clears the block.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            block_q     <= '0;
            round_ctr_q <= '0;
            word_ctr_q  <= '0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            block_q     <= block_d;
            round_ctr_q <= round_ctr_d;
            word_ctr_q  <= word_ctr_d;
            ready_q     <= ready_d;
        end
    end

endmodule
